// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce filter and its synchronizer.
// Optional feature macro used by this block: DEBOUNCE_EDGE_TICK_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT     = 20;

  // Debounced level implied by a state: high once a rise is qualified,
  // and it stays high while a fall is still being qualified.
  function automatic logic level_of(input db_state_e s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_filter_if.sv
// Signal bundle between the raw input source and the debounce filter.
// db_tick exists only when DEBOUNCE_EDGE_TICK_EN is defined.
interface debounce_filter_if;

  logic raw_in;
  logic db_level;
`ifdef DEBOUNCE_EDGE_TICK_EN
  logic db_tick;
`endif

  modport slave (
    input  raw_in,
    output db_level
`ifdef DEBOUNCE_EDGE_TICK_EN
    ,
    output db_tick
`endif
  );

  modport master (
    output raw_in,
    input  db_level
`ifdef DEBOUNCE_EDGE_TICK_EN
    ,
    input  db_tick
`endif
  );

endinterface

// File: rtl/debounce_filter_sync_chain.sv
// Plain flop chain bringing an asynchronous level into the clk domain.
// Synchronous active-low reset clears every stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Synchronizer plus counter-qualified 4-state debounce FSM producing a clean level.
// DEBOUNCE_EDGE_TICK_EN adds a registered one-cycle pulse on every level change.
//
// state | meaning
// ZERO  | stable low
// WAIT1 | input high, counting toward a qualified rise
// ONE   | stable high
// WAIT0 | input low, counting toward a qualified fall
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int          CNT_W       = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  debounce_filter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_in;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.raw_in),
    .q_o (sync_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (sync_in) begin
          state_d = WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!sync_in) begin
          state_d = ZERO;
        end else if (cnt_q == '0) begin
          state_d = ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ONE: begin
        if (!sync_in) begin
          state_d = WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (sync_in) begin
          state_d = ONE;
        end else if (cnt_q == '0) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
    // Level is registered from the next state so it moves on the qualifying edge itself.
    level_d = level_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign bus.db_level = level_q;

`ifdef DEBOUNCE_EDGE_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = ((state_q == WAIT1) && (state_d == ONE)) ||
             ((state_q == WAIT0) && (state_d == ZERO));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign bus.db_tick = tick_q;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter (SYNC_STAGES=2, DB_CYCLES=4), with or without
// DEBOUNCE_EDGE_TICK_EN, against a run-length reference model.
module tb_debounce_filter;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LAT  = SYNC + DB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debounce_filter_if dif ();

  debounce_filter #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .CNT_W       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the level flips once DB+1 consecutive synchronized samples disagree with it.
  bit m_sync [SYNC];
  int m_run;
  bit m_lvl;
  bit m_tick;

  function automatic logic tick_obs();
`ifdef DEBOUNCE_EDGE_TICK_EN
    return dif.db_tick;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit r, input bit x);
    bit s;
    @(negedge clk);
    rst        = r;
    dif.raw_in = x;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      m_run  = 0;
      m_lvl  = 1'b0;
      m_tick = 1'b0;
    end else begin
      s = m_sync[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = x;
      m_tick    = 1'b0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_lvl  = !m_lvl;
          m_run  = 0;
          m_tick = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1);
      checks++;
      if (dif.db_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_level cyc=%0d got=%b exp=0", c, dif.db_level);
      end
`ifdef DEBOUNCE_EDGE_TICK_EN
      checks++;
      if (dif.db_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_tick cyc=%0d got=%b exp=0", c, dif.db_tick);
      end
`endif
    end
  endtask

  // Drives a level for n cycles from a known start, comparing each cycle to the model,
  // and reports the first cycle index at which db_level equals 'target' (-1 if never).
  task automatic run_level(input string name, input bit x, input int n, input bit target,
                           output int first_hit, output int ticks);
    first_hit = -1;
    ticks     = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b1, x);
      checks++;
      if (dif.db_level !== m_lvl) begin
        errors++;
        $display("FAIL %s_level k=%0d got=%b exp=%b", name, k, dif.db_level, m_lvl);
      end
`ifdef DEBOUNCE_EDGE_TICK_EN
      checks++;
      if (dif.db_tick !== m_tick) begin
        errors++;
        $display("FAIL %s_tick k=%0d got=%b exp=%b", name, k, dif.db_tick, m_tick);
      end
`endif
      if (tick_obs() === 1'b1) ticks++;
      if (first_hit < 0 && dif.db_level === target) first_hit = k;
    end
  endtask

  task automatic go_zero();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic test_clean_rise();
    int hit, ticks;
    go_zero();
    run_level("rise", 1'b1, 15, 1'b1, hit, ticks);
    checks++;
    if (hit !== LAT) begin
      errors++;
      $display("FAIL rise_latency got=%0d exp=%0d", hit, LAT);
    end
`ifdef DEBOUNCE_EDGE_TICK_EN
    checks++;
    if (ticks !== 1) begin
      errors++;
      $display("FAIL rise_tick_count got=%0d exp=1", ticks);
    end
`endif
  endtask

  task automatic test_bounce();
    int hit, ticks;
    go_zero();
    run_level("bounce_pre", 1'b1, 3, 1'b1, hit, ticks);
    checks++;
    if (hit !== -1) begin
      errors++;
      $display("FAIL bounce_early got=%0d exp=-1", hit);
    end
    run_level("bounce_gap", 1'b0, 1, 1'b1, hit, ticks);
    run_level("bounce_hold", 1'b1, 15, 1'b1, hit, ticks);
    checks++;
    if (hit !== LAT) begin
      errors++;
      $display("FAIL bounce_latency got=%0d exp=%0d", hit, LAT);
    end
  endtask

  task automatic test_short_pulse();
    int hit1, hit2, t1, t2;
    go_zero();
    run_level("pulse_hi", 1'b1, DB, 1'b1, hit1, t1);
    run_level("pulse_lo", 1'b0, 12, 1'b1, hit2, t2);
    checks++;
    if (hit1 !== -1 || hit2 !== -1) begin
      errors++;
      $display("FAIL short_pulse_level got=%0d/%0d exp=-1/-1", hit1, hit2);
    end
`ifdef DEBOUNCE_EDGE_TICK_EN
    checks++;
    if (t1 + t2 !== 0) begin
      errors++;
      $display("FAIL short_pulse_tick got=%0d exp=0", t1 + t2);
    end
`endif
  endtask

  task automatic test_clean_fall();
    int hit, ticks;
    go_zero();
    run_level("fall_setup", 1'b1, 12, 1'b1, hit, ticks);
    checks++;
    if (dif.db_level !== 1'b1) begin
      errors++;
      $display("FAIL fall_setup got=%b exp=1", dif.db_level);
    end
    run_level("fall", 1'b0, 15, 1'b0, hit, ticks);
    checks++;
    if (hit !== LAT) begin
      errors++;
      $display("FAIL fall_latency got=%0d exp=%0d", hit, LAT);
    end
`ifdef DEBOUNCE_EDGE_TICK_EN
    checks++;
    if (ticks !== 1) begin
      errors++;
      $display("FAIL fall_tick_count got=%0d exp=1", ticks);
    end
`endif
  endtask

  task automatic test_reset_mid_wait1();
    int hit, ticks;
    go_zero();
    // Edge j+2 enters WAIT1 with cnt=3; after edge j+3 cnt=2.
    run_level("midrst_pre", 1'b1, 4, 1'b1, hit, ticks);
    step(1'b0, 1'b1);
    checks++;
    if (dif.db_level !== 1'b0 || m_lvl !== 1'b0) begin
      errors++;
      $display("FAIL midrst_level got=%b exp=0", dif.db_level);
    end
    run_level("midrst_post", 1'b1, 15, 1'b1, hit, ticks);
    checks++;
    if (hit !== LAT) begin
      errors++;
      $display("FAIL midrst_latency got=%0d exp=%0d", hit, LAT);
    end
  endtask

  task automatic test_random();
    bit x = 1'b0;
    int hold = 0;
    bit r;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        x    = $urandom_range(0, 1);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(DB, DB + 6) : $urandom_range(1, 4);
      end
      hold--;
      r = ($urandom_range(0, 199) != 0);
      step(r, x);
      checks++;
      if (dif.db_level !== m_lvl) begin
        errors++;
        $display("FAIL random_level cyc=%0d got=%b exp=%b", c, dif.db_level, m_lvl);
      end
`ifdef DEBOUNCE_EDGE_TICK_EN
      checks++;
      if (dif.db_tick !== m_tick) begin
        errors++;
        $display("FAIL random_tick cyc=%0d got=%b exp=%b", c, dif.db_tick, m_tick);
      end
`endif
    end
  endtask

  initial begin
    dif.raw_in = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_short_pulse();
    test_clean_fall();
    test_reset_mid_wait1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
